// File: rtl/sum_seq_pkg.sv
// Shared types and default sizing for the sum_seq_ctrl chunked adder sequencer.
package sum_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_SIZE_DATA = 8;
  localparam int DEF_NUM_CHUNK = 4;

endpackage

// File: rtl/SUM_unit.sv
// Narrow SIZE_DATA-bit adder with carry-in/carry-out; the only adder in sum_seq_ctrl.
module SUM_unit #(
  parameter int SIZE_DATA = 8
) (
  input  logic [SIZE_DATA-1:0] i_a,
  input  logic [SIZE_DATA-1:0] i_b,
  input  logic                 i_carry,
  output logic [SIZE_DATA-1:0] o_sum,
  output logic                 o_carry
);

  assign {o_carry, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{SIZE_DATA{1'b0}}, i_carry};

endmodule

// File: rtl/sum_seq_ctrl.sv
// Wide add (or subtract when SUM_SEQ_SUB_EN is defined) computed one SIZE_DATA chunk per
// cycle through a single SUM_unit, LSB chunk first, with valid/ready on both sides.
module sum_seq_ctrl
  import sum_seq_pkg::*;
#(
  parameter int SIZE_DATA = DEF_SIZE_DATA,
  parameter int NUM_CHUNK = DEF_NUM_CHUNK
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_valid,
  output logic                           o_ready,
  input  logic [SIZE_DATA*NUM_CHUNK-1:0] i_data_a,
  input  logic [SIZE_DATA*NUM_CHUNK-1:0] i_data_b,
  input  logic                           i_carry,
`ifdef SUM_SEQ_SUB_EN
  input  logic                           i_sub,
`endif
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [SIZE_DATA*NUM_CHUNK-1:0] o_sum,
  output logic                           o_carry,
  output logic                           o_busy
);

  localparam int W     = SIZE_DATA * NUM_CHUNK;
  localparam int CNT_W = $clog2(NUM_CHUNK);
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNK - 1);

  state_t               state;
  logic [W-1:0]         a_reg;
  logic [W-1:0]         b_reg;
  logic [W-1:0]         sum_reg;
  logic                 carry_reg;
  logic [CNT_W-1:0]     cnt;
  logic [SIZE_DATA-1:0] chunk_sum;
  logic                 chunk_carry;
  logic [W-1:0]         b_load;
  logic                 carry_load;

`ifdef SUM_SEQ_SUB_EN
  // A - B is formed as A + ~B + 1, so a set carry-out means no borrow.
  assign b_load     = i_sub ? ~i_data_b : i_data_b;
  assign carry_load = i_sub ? 1'b1 : i_carry;
`else
  assign b_load     = i_data_b;
  assign carry_load = i_carry;
`endif

  SUM_unit #(
    .SIZE_DATA(SIZE_DATA)
  ) u_sum_unit (
    .i_a     (a_reg[SIZE_DATA-1:0]),
    .i_b     (b_reg[SIZE_DATA-1:0]),
    .i_carry (carry_reg),
    .o_sum   (chunk_sum),
    .o_carry (chunk_carry)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
      o_ready   <= 1'b1;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            a_reg     <= i_data_a;
            b_reg     <= b_load;
            carry_reg <= carry_load;
            cnt       <= '0;
            o_ready   <= 1'b0;
            o_busy    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          // Each chunk result enters at the top so the first (LSB) chunk ends up at the bottom.
          sum_reg   <= {chunk_sum, sum_reg[W-1:SIZE_DATA]};
          carry_reg <= chunk_carry;
          a_reg     <= a_reg >> SIZE_DATA;
          b_reg     <= b_reg >> SIZE_DATA;
          if (cnt == LAST_CHUNK) begin
            o_busy  <= 1'b0;
            o_valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (i_ready) begin
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          o_ready <= 1'b1;
          o_valid <= 1'b0;
          o_busy  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign o_sum   = sum_reg;
  assign o_carry = carry_reg;

endmodule

// File: tb/tb_sum_seq_ctrl.sv
// Directed and random bench for sum_seq_ctrl with SIZE_DATA=8, NUM_CHUNK=4.
module tb_sum_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data_a;
  logic [31:0] i_data_b;
  logic        i_carry;
  logic        i_sub;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_sum;
  logic        o_carry;
  logic        o_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 i_clk = ~i_clk;

  sum_seq_ctrl #(
    .SIZE_DATA(8),
    .NUM_CHUNK(4)
  ) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_data_a (i_data_a),
    .i_data_b (i_data_b),
    .i_carry  (i_carry),
`ifdef SUM_SEQ_SUB_EN
    .i_sub    (i_sub),
`endif
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_sum    (o_sum),
    .o_carry  (o_carry),
    .o_busy   (o_busy)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic [31:0] s;
    logic        c;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Issue one operation from a negedge, wait for the result, then hold it for `stall` cycles.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                       input logic sub, input int stall,
                       output logic [31:0] s, output logic c, output int lat,
                       output int busy_n, output logic tmo);
    int guard;
    tmo = 1'b0;
    guard = 0;
    while (!o_ready && guard < 20) begin
      @(negedge i_clk);
      guard++;
    end
    if (!o_ready) tmo = 1'b1;
    i_data_a = a;
    i_data_b = b;
    i_carry  = cin;
    i_sub    = sub;
    i_valid  = 1'b1;
    @(negedge i_clk);
    i_valid  = 1'b0;
    i_data_a = $urandom;
    i_data_b = $urandom;
    i_carry  = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!o_valid && lat < 50) begin
      if (o_busy) busy_n++;
      @(negedge i_clk);
      lat++;
    end
    if (o_busy) busy_n++;
    if (!o_valid) tmo = 1'b1;
    s = o_sum;
    c = o_carry;
    for (int k = 0; k < stall; k++) @(negedge i_clk);
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] s;
    logic        c;
    int          lat;
    int          busy_n;
    logic        tmo;
    logic [32:0] ref_sum;
    logic        bad;
    int          rand_fail;
    int          seen;

    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1};
    tbl[1] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0};
    tbl[2] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0};
    tbl[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1};
    tbl[4] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1};
    tbl[5] = '{32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0};
    tbl[6] = '{32'h00FFFFFF, 32'h00000000, 1'b1, 32'h01000000, 1'b0};
    tbl[7] = '{32'hDEADBEEF, 32'h00000000, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[8] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0};
    tbl[9] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1};

    i_rst_n  = 1'b0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;
    i_data_a = '0;
    i_data_b = '0;
    i_carry  = 1'b0;
    i_sub    = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_busy",  64'(o_busy),  64'd0);
    chk("rst_sum",   64'(o_sum),   64'd0);
    chk("rst_carry", 64'(o_carry), 64'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    for (int i = 0; i < 10; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].cin, 1'b0, i % 3, s, c, lat, busy_n, tmo);
      chk($sformatf("vec%0d_timeout", i), 64'(tmo), 64'd0);
      chk($sformatf("vec%0d_sum", i), 64'(s), 64'(tbl[i].s));
      chk($sformatf("vec%0d_carry", i), 64'(c), 64'(tbl[i].c));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(busy_n), 64'd4);
      chk($sformatf("vec%0d_valid_drop", i), 64'(o_valid), 64'd0);
      chk($sformatf("vec%0d_ready_back", i), 64'(o_ready), 64'd1);
    end

    // Backpressure: result held in DONE while i_valid toggles with new data.
    i_data_a = 32'h12345678;
    i_data_b = 32'h11111111;
    i_carry  = 1'b1;
    i_valid  = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (4) @(negedge i_clk);
    chk("bp_valid_rise", 64'(o_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      i_valid  = k[0];
      i_data_a = $urandom;
      i_data_b = $urandom;
      @(negedge i_clk);
      chk($sformatf("bp%0d_valid", k), 64'(o_valid), 64'd1);
      chk($sformatf("bp%0d_sum", k), 64'(o_sum), 64'h2345678A);
      chk($sformatf("bp%0d_carry", k), 64'(o_carry), 64'd0);
      chk($sformatf("bp%0d_ready", k), 64'(o_ready), 64'd0);
      chk($sformatf("bp%0d_busy", k), 64'(o_busy), 64'd0);
    end
    i_valid = 1'b1;
    i_ready = 1'b1;
    @(negedge i_clk);
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk("bp_idle_valid", 64'(o_valid), 64'd0);
    chk("bp_idle_ready", 64'(o_ready), 64'd1);
    chk("bp_idle_sum_hold", 64'(o_sum), 64'h2345678A);
    @(negedge i_clk);
    chk("bp_no_accept_busy", 64'(o_busy), 64'd0);
    chk("bp_no_accept_ready", 64'(o_ready), 64'd1);

    // Reset in the middle of RUN aborts the operation.
    i_data_a = 32'hA5A5A5A5;
    i_data_b = 32'h5A5A5A5A;
    i_carry  = 1'b1;
    i_valid  = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("abort_busy_before", 64'(o_busy), 64'd1);
    i_rst_n = 1'b0;
    #1;
    chk("abort_valid", 64'(o_valid), 64'd0);
    chk("abort_ready", 64'(o_ready), 64'd1);
    chk("abort_busy",  64'(o_busy),  64'd0);
    chk("abort_sum",   64'(o_sum),   64'd0);
    chk("abort_carry", 64'(o_carry), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge i_clk);
      if (o_valid || o_busy || !o_ready) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

`ifdef SUM_SEQ_SUB_EN
    do_op(32'd5, 32'd7, 1'b0, 1'b1, 0, s, c, lat, busy_n, tmo);
    chk("sub_5_7_sum", 64'(s), 64'hFFFFFFFE);
    chk("sub_5_7_carry", 64'(c), 64'd0);
    do_op(32'd7, 32'd5, 1'b0, 1'b1, 1, s, c, lat, busy_n, tmo);
    chk("sub_7_5_sum", 64'(s), 64'h00000002);
    chk("sub_7_5_carry", 64'(c), 64'd1);
    i_sub = 1'b0;
`endif

    rand_fail = 0;
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rc;
      ra = $urandom;
      rb = $urandom;
      rc = 1'($urandom_range(0, 1));
      ref_sum = {1'b0, ra} + {1'b0, rb} + {32'd0, rc};
      do_op(ra, rb, rc, 1'b0, $urandom_range(0, 3), s, c, lat, busy_n, tmo);
      bad = tmo || (s !== ref_sum[31:0]) || (c !== ref_sum[32]) || (lat != 4) || o_valid;
      if (bad && rand_fail < 5)
        $display("FAIL rand%0d got=%h/%b lat=%0d exp=%h/%b", i, s, c, lat, ref_sum[31:0], ref_sum[32]);
      if (bad) rand_fail++;
      n_chk++;
      if (bad) n_fail++;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_seq_ctrl.md
# sum_seq_ctrl

Multi-cycle sequencer that adds wide operands using one narrow `SUM_unit` adder. The `SUM_unit` is SIZE_DATA bits wide. The controller feeds it one SIZE_DATA chunk per cycle, least-significant chunk first, and carries the chain between chunks in a register. It sits between the mantissa-alignment stage and normalisation in the floating-point datapath. Both sides use valid/ready handshakes.

## Interface
Parameters:
- SIZE_DATA, 8, width of one chunk; this is the width of the instantiated `SUM_unit`.
- NUM_CHUNK, 4, number of chunks per operand (≥2). The full operand width is W = SIZE_DATA*NUM_CHUNK.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_valid  in  1  an operand set is presented on the inputs.
- o_ready  out  1  the block can accept an operand set.
- i_data_a  in  W  operand A.
- i_data_b  in  W  operand B.
- i_carry  in  1  carry-in to the least-significant chunk.
- i_sub  in  1  subtract request; this port exists only when SUM_SEQ_SUB_EN is defined.
- o_valid  out  1  o_sum and o_carry hold a valid result.
- i_ready  in  1  the downstream stage takes the result.
- o_sum  out  W  result.
- o_carry  out  1  carry-out of the most-significant chunk.
- o_busy  out  1  high while the state is RUN.

## Operation
- FSM states: IDLE, RUN, DONE. The reset state is IDLE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready: latch A and B into shift registers, load carry_reg=i_carry, clear chunk counter, go to RUN.
- RUN:
  - Each cycle the `SUM_unit` adds A_reg[SIZE_DATA-1:0] + B_reg[SIZE_DATA-1:0] + carry_reg.
  - Its sum shifts into the MSB end of sum_reg; its carry-out loads carry_reg.
  - A_reg and B_reg shift right by SIZE_DATA.
  - The counter increments. When counter==NUM_CHUNK-1, go to DONE.
- DONE:
  - o_valid=1; o_sum=sum_reg; o_carry=carry_reg.
  - On i_ready: go to IDLE.
- o_ready is 1 only in IDLE. i_valid in RUN or DONE is ignored; the upstream stage must hold its data.
- Arithmetic: o_sum = (A + B + cin) mod 2^W. o_carry is bit W of that sum, with unsigned zero-extension.
- The chunk counter is $clog2(NUM_CHUNK) bits wide and does not wrap past NUM_CHUNK-1.

## Timing
- Reset values: o_valid=0, o_ready=1, o_busy=0, o_sum=0, o_carry=0. All internal registers are 0.
- Latency: with the accept on edge T, o_valid rises after edge T+NUM_CHUNK.
- Minimum issue period is NUM_CHUNK+2 cycles: NUM_CHUNK RUN cycles, at least 1 DONE cycle, 1 IDLE cycle.
- o_sum and o_carry are registered. They are stable from o_valid rise until the cycle after the i_ready handshake.
- Backpressure: with i_ready low, the block holds DONE indefinitely and keeps its outputs unchanged.
- i_valid together with i_ready in DONE: the result handshakes, and the new input is not accepted until IDLE.
- Reset asserted mid-RUN or mid-DONE: the operation aborts immediately with no o_valid pulse. The block resumes in IDLE.

## Configuration
- SUM_SEQ_SUB_EN defined:
  - The i_sub port exists.
  - On accept with i_sub=1, B_reg loads ~i_data_b and carry_reg loads 1; i_carry is ignored.
  - o_sum = A−B mod 2^W. o_carry=1 means no borrow (A≥B).
- Undefined: the i_sub port and its logic are absent, and the block always adds.

## Structure
- Package sum_seq_pkg holds:
  - the state enum typedef (IDLE, RUN, DONE);
  - the default SIZE_DATA and NUM_CHUNK constants.
- One sub-module: the existing `SUM_unit`, instantiated once with SIZE_DATA. No other adder exists in the block.

## Test plan
All scenarios use SIZE_DATA=8 and NUM_CHUNK=4.
- A=0xFFFFFFFF, B=0x00000001, cin=0 → o_sum=0x00000000, o_carry=1. o_valid rises exactly 4 cycles after the accept edge.
- A=0x12345678, B=0x11111111, cin=1 → o_sum=0x2345678A, o_carry=0. o_busy is high for exactly 4 cycles.
- Hold i_ready=0 for 5 cycles while in DONE, and toggle i_valid → o_valid, o_sum and o_carry stay constant, o_ready=0, no new accept. One i_ready pulse → IDLE next cycle.
- Assert i_rst_n=0 after 2 RUN cycles → all outputs return to their reset values at once. o_ready=1 after release, and no o_valid pulse from the aborted operation.
- SUM_SEQ_SUB_EN defined:
  - A=5, B=7, i_sub=1 → 0xFFFFFFFE, o_carry=0.
  - A=7, B=5, i_sub=1 → 0x00000002, o_carry=1.
- Random regression: 1000 random A/B/cin with random i_ready stalls, checked against the W+1-bit sum → zero mismatches, and no dropped or duplicated results.
